secure_debug_readout: RTL and testbench
=======================================

// Module: secure_debug_readout
// PURPOSE
//  Parametrised, access-controlled debug readout for a bank of sensitive registers (keys, internal state).
//  Reads are served only after a challenge unlock against auth register 0; otherwise they return zero with an error flag.
//  Includes a failed-attempt lockout, an inactivity relock timer and a valid/ready debug response channel.
//  Sits between the debug transport and the secure key store.
// PARAMETERS
//  WIDTH      32  data width of each register, of unlock code and of debug data
//  N_REGS     8   number of sensitive registers, >=2; index 0 is the auth register and is never readable
//  MAX_FAILS  3   consecutive failed unlocks before permanent LOCKOUT, >=1
//  TIMEOUT    255 idle cycles in UNLOCKED before automatic relock, >=1
//  IDX_W      $clog2(N_REGS)  derived index width
// PORTS
//  clk            in   1       single clock; all logic on posedge
//  rst            in   1       asynchronous, active-high reset
//  key_wr_en      in   1       provisioning write strobe
//  key_wr_idx     in   IDX_W   provisioning register index
//  key_wr_data    in   WIDTH   provisioning data
//  unlock_valid   in   1       unlock attempt valid
//  unlock_ready   out  1       attempt accepted (high only in LOCKED)
//  unlock_code    in   WIDTH   candidate code
//  relock         in   1       force relock pulse
//  dbg_req_valid  in   1       read request valid
//  dbg_req_ready  out  1       read request accepted
//  dbg_req_idx    in   IDX_W   register to read
//  dbg_rsp_valid  out  1       response valid
//  dbg_rsp_ready  in   1       response consumed
//  dbg_rsp_data   out  WIDTH   read data; 0 when denied
//  dbg_rsp_err    out  1       access denied or index out of range
//  unlocked       out  1       state==UNLOCKED
//  locked_out     out  1       state==LOCKOUT
// BEHAVIOUR
//  Reset: state LOCKED; registers, fail_cnt, timer and every output 0 except unlock_ready=1 and dbg_req_ready=1.
//  FSM LOCKED->CHECK on unlock handshake; code registered.
//  CHECK, 1 cycle: if code==reg[0] and reg[0]!=0, go to UNLOCKED, clear fail_cnt, load timer=TIMEOUT.
//  Otherwise fail_cnt++; fail_cnt reaching MAX_FAILS goes to LOCKOUT, else back to LOCKED.
//  UNLOCKED: timer decrements each cycle; each accepted dbg request reloads TIMEOUT.
//  UNLOCKED exits to LOCKED on timer==0 or relock=1 (relock takes priority over a same-cycle request reload).
//  LOCKOUT is terminal until rst; unlock_ready=0; relock ignored.
//  Provisioning: key_wr_en is honoured only in LOCKED; it is ignored in CHECK, UNLOCKED and LOCKOUT, and for idx>=N_REGS.
//  Read channel: dbg_req_ready = !dbg_rsp_valid || dbg_rsp_ready (one-entry skid-free output register).
//  Response latency is 1 cycle after handshake. The output is held stable while dbg_rsp_valid && !dbg_rsp_ready.
//  A grant is decided by state at handshake: state==UNLOCKED && idx!=0 && idx<N_REGS gives data=reg[idx], err=0.
//  Otherwise data=0 and err=1.
//  Same-cycle provisioning write and read of the same idx: the read returns the pre-write value.
//  Relock or timeout in the cycle after a granted handshake does not retract the already-registered response.
//  Async rst mid-transaction drops the pending response immediately (dbg_rsp_valid=0).
// CONFIGURATION
//  DBG_ZEROIZE_EN defined: on the CHECK->LOCKOUT transition, all N_REGS registers, including reg[0], clear to 0 in that same edge.
//  Not defined: register contents are retained in LOCKOUT but remain unreadable (err=1, data=0).
// TESTING
//  Reset, provision reg0=0xA5A5_0001, reg3=0xDEAD_BEEF; read idx3 while LOCKED -> data=0, err=1.
//  Unlock with 0xA5A5_0001 -> unlocked=1 two cycles after handshake; read idx3 -> 0xDEAD_BEEF, err=0; read idx0 -> 0, err=1.
//  Three wrong codes (MAX_FAILS=3) -> locked_out=1, unlock_ready=0; a correct code afterwards is ignored.
//  With DBG_ZEROIZE_EN, regs read 0 after rst.
//  Unlock, then idle TIMEOUT=4 cycles -> unlocked drops; a read issued every 3 cycles keeps unlocked=1.
//  Hold dbg_rsp_ready=0 across 3 requests -> dbg_req_ready=0, data stable, no response lost.
//  Assert relock and request in the same cycle -> response err=0, state LOCKED next.

Source files
------------

// File: rtl/secure_debug_readout.sv
// Access-controlled debug readout of a sensitive register bank: challenge unlock, lockout, idle relock.
// Optional build macro DBG_ZEROIZE_EN clears the whole bank when the lockout state is entered.
module secure_debug_readout #(
  parameter int WIDTH     = 32,
  parameter int N_REGS    = 8,
  parameter int MAX_FAILS = 3,
  parameter int TIMEOUT   = 255,
  localparam int IDX_W    = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_wr_en,
  input  logic [IDX_W-1:0] key_wr_idx,
  input  logic [WIDTH-1:0] key_wr_data,
  input  logic             unlock_valid,
  output logic             unlock_ready,
  input  logic [WIDTH-1:0] unlock_code,
  input  logic             relock,
  input  logic             dbg_req_valid,
  output logic             dbg_req_ready,
  input  logic [IDX_W-1:0] dbg_req_idx,
  output logic             dbg_rsp_valid,
  input  logic             dbg_rsp_ready,
  output logic [WIDTH-1:0] dbg_rsp_data,
  output logic             dbg_rsp_err,
  output logic             unlocked,
  output logic             locked_out
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam logic [IDX_W:0] N_REGS_X = (IDX_W + 1)'(N_REGS);

  typedef enum logic [1:0] {
    S_LOCKED,
    S_CHECK,
    S_UNLOCKED,
    S_LOCKOUT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic [FW-1:0]    fail_cnt_q, fail_cnt_d;
  logic [FW-1:0]    fail_next;
  logic [TW-1:0]    timer_q, timer_d;
  logic [WIDTH-1:0] regs_q [N_REGS];
  logic [WIDTH-1:0] regs_d [N_REGS];
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic unlock_fire;
  logic req_fire;
  logic code_match;
  logic wr_idx_ok;
  logic rd_idx_ok;
  logic grant;

  assign unlock_ready  = (state_q == S_LOCKED);
  assign dbg_req_ready = !rsp_valid_q || dbg_rsp_ready;
  assign unlock_fire   = unlock_valid && unlock_ready;
  assign req_fire      = dbg_req_valid && dbg_req_ready;
  assign code_match    = (code_q == regs_q[0]) && (regs_q[0] != '0);
  assign wr_idx_ok     = ({1'b0, key_wr_idx} < N_REGS_X);
  assign rd_idx_ok     = ({1'b0, dbg_req_idx} < N_REGS_X);
  assign grant         = (state_q == S_UNLOCKED) && (dbg_req_idx != '0) && rd_idx_ok;
  assign fail_next     = fail_cnt_q + FW'(1);

  assign dbg_rsp_valid = rsp_valid_q;
  assign dbg_rsp_data  = rsp_data_q;
  assign dbg_rsp_err   = rsp_err_q;
  assign unlocked      = (state_q == S_UNLOCKED);
  assign locked_out    = (state_q == S_LOCKOUT);

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    fail_cnt_d = fail_cnt_q;
    timer_d    = timer_q;
    for (int i = 0; i < N_REGS; i++) regs_d[i] = regs_q[i];

    case (state_q)
      S_LOCKED: begin
        if (unlock_fire) begin
          state_d = S_CHECK;
          code_d  = unlock_code;
        end
        if (key_wr_en && wr_idx_ok) regs_d[key_wr_idx] = key_wr_data;
      end
      S_CHECK: begin
        if (code_match) begin
          state_d    = S_UNLOCKED;
          fail_cnt_d = '0;
          timer_d    = TW'(TIMEOUT);
        end else begin
          fail_cnt_d = fail_next;
          if (int'(fail_next) >= MAX_FAILS) begin
            state_d = S_LOCKOUT;
`ifdef DBG_ZEROIZE_EN
            for (int i = 0; i < N_REGS; i++) regs_d[i] = '0;
`else
            regs_d[0] = regs_q[0];
`endif
          end else begin
            state_d = S_LOCKED;
          end
        end
      end
      // Relock wins over everything; an expired timer wins over a reload from a request.
      S_UNLOCKED: begin
        if (relock || (timer_q == '0)) begin
          state_d = S_LOCKED;
        end else if (req_fire) begin
          timer_d = TW'(TIMEOUT);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_LOCKOUT: begin
        state_d = S_LOCKOUT;
      end
      default: begin
        state_d = S_LOCKED;
      end
    endcase
  end

  // Grant is judged on the state and register contents before this edge's updates.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    if (req_fire) begin
      rsp_valid_d = 1'b1;
      if (grant) begin
        rsp_data_d = regs_q[dbg_req_idx];
        rsp_err_d  = 1'b0;
      end else begin
        rsp_data_d = '0;
        rsp_err_d  = 1'b1;
      end
    end else if (dbg_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOCKED;
      code_q      <= '0;
      fail_cnt_q  <= '0;
      timer_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      fail_cnt_q  <= fail_cnt_d;
      timer_q     <= timer_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: tb/tb_secure_debug_readout.sv
// Directed self-checking bench for secure_debug_readout (WIDTH=32, N_REGS=8, MAX_FAILS=3, TIMEOUT=4).
module tb_secure_debug_readout;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_wr_en;
  logic [2:0]  key_wr_idx;
  logic [31:0] key_wr_data;
  logic        unlock_valid;
  logic        unlock_ready;
  logic [31:0] unlock_code;
  logic        relock;
  logic        dbg_req_valid;
  logic        dbg_req_ready;
  logic [2:0]  dbg_req_idx;
  logic        dbg_rsp_valid;
  logic        dbg_rsp_ready;
  logic [31:0] dbg_rsp_data;
  logic        dbg_rsp_err;
  logic        unlocked;
  logic        locked_out;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] AUTH = 32'hA5A5_0001;
  localparam logic [31:0] KEY3 = 32'hDEAD_BEEF;

  secure_debug_readout #(
    .WIDTH(32), .N_REGS(8), .MAX_FAILS(3), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
    .unlock_valid(unlock_valid), .unlock_ready(unlock_ready), .unlock_code(unlock_code),
    .relock(relock),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_idx(dbg_req_idx),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
    .dbg_rsp_data(dbg_rsp_data), .dbg_rsp_err(dbg_rsp_err),
    .unlocked(unlocked), .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic req_v, input logic [2:0] idx,
                               input logic unl_v, input logic [31:0] code, input logic rl);
    dbg_req_valid = req_v;
    dbg_req_idx   = idx;
    unlock_valid  = unl_v;
    unlock_code   = code;
    relock        = rl;
  endtask

  task automatic provision(input logic [2:0] idx, input logic [31:0] data);
    key_wr_en   = 1'b1;
    key_wr_idx  = idx;
    key_wr_data = data;
    tick();
    key_wr_en   = 1'b0;
  endtask

  task automatic readReg(input logic [2:0] idx);
    applyStimulus(1'b1, idx, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic unlockAttempt(input logic [31:0] code);
    applyStimulus(1'b0, 3'd0, 1'b1, code, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    key_wr_en = 1'b0; key_wr_idx = '0; key_wr_data = '0;
    dbg_rsp_ready = 1'b1;
    applyStimulus(1'b0, 3'd0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    checkOutput("rst_unlock_ready", {31'b0, unlock_ready}, 32'd1);
    checkOutput("rst_req_ready", {31'b0, dbg_req_ready}, 32'd1);
    checkOutput("rst_rsp_valid", {31'b0, dbg_rsp_valid}, 32'd0);
    checkOutput("rst_rsp_data", dbg_rsp_data, 32'd0);
    checkOutput("rst_rsp_err", {31'b0, dbg_rsp_err}, 32'd0);
    checkOutput("rst_unlocked", {31'b0, unlocked}, 32'd0);
    checkOutput("rst_locked_out", {31'b0, locked_out}, 32'd0);
    rst = 1'b0;
    tick();

    provision(3'd0, AUTH);
    provision(3'd3, KEY3);
    readReg(3'd3);
    checkOutput("locked_read_valid", {31'b0, dbg_rsp_valid}, 32'd1);
    checkOutput("locked_read_data", dbg_rsp_data, 32'd0);
    checkOutput("locked_read_err", {31'b0, dbg_rsp_err}, 32'd1);

    unlockAttempt(AUTH);
    checkOutput("check_unlocked", {31'b0, unlocked}, 32'd0);
    checkOutput("check_unlock_ready", {31'b0, unlock_ready}, 32'd0);
    tick();
    checkOutput("unlock_ok", {31'b0, unlocked}, 32'd1);
    readReg(3'd3);
    checkOutput("read3_data", dbg_rsp_data, KEY3);
    checkOutput("read3_err", {31'b0, dbg_rsp_err}, 32'd0);
    readReg(3'd0);
    checkOutput("read0_data", dbg_rsp_data, 32'd0);
    checkOutput("read0_err", {31'b0, dbg_rsp_err}, 32'd1);
    provision(3'd3, 32'h0000_1234);
    readReg(3'd3);
    checkOutput("wr_ignored_unlocked", dbg_rsp_data, KEY3);
    readReg(3'd7);
    checkOutput("read7_data", dbg_rsp_data, 32'd0);
    checkOutput("read7_err", {31'b0, dbg_rsp_err}, 32'd0);

    for (int k = 0; k < 3; k++) begin
      readReg(3'd3);
      tick();
      tick();
      checkOutput("keepalive", {31'b0, unlocked}, 32'd1);
    end
    readReg(3'd3);
    repeat (4) tick();
    checkOutput("idle_still_unlocked", {31'b0, unlocked}, 32'd1);
    tick();
    checkOutput("idle_relocked", {31'b0, unlocked}, 32'd0);
    checkOutput("idle_unlock_ready", {31'b0, unlock_ready}, 32'd1);

    unlockAttempt(AUTH);
    tick();
    checkOutput("bp_unlocked", {31'b0, unlocked}, 32'd1);
    dbg_rsp_ready = 1'b0;
    applyStimulus(1'b1, 3'd3, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("bp_first_data", dbg_rsp_data, KEY3);
    checkOutput("bp_req_ready", {31'b0, dbg_req_ready}, 32'd0);
    dbg_req_idx = 3'd0;
    tick();
    tick();
    checkOutput("bp_held_data", dbg_rsp_data, KEY3);
    checkOutput("bp_held_valid", {31'b0, dbg_rsp_valid}, 32'd1);
    checkOutput("bp_held_err", {31'b0, dbg_rsp_err}, 32'd0);
    dbg_rsp_ready = 1'b1;
    tick();
    dbg_rsp_ready = 1'b0;
    checkOutput("bp_second_data", dbg_rsp_data, 32'd0);
    checkOutput("bp_second_err", {31'b0, dbg_rsp_err}, 32'd1);
    dbg_req_idx = 3'd3;
    tick();
    checkOutput("bp_second_held", {31'b0, dbg_rsp_err}, 32'd1);
    dbg_rsp_ready = 1'b1;
    tick();
    applyStimulus(1'b0, 3'd0, 1'b0, 32'h0, 1'b0);
    checkOutput("bp_third_data", dbg_rsp_data, KEY3);
    checkOutput("bp_third_err", {31'b0, dbg_rsp_err}, 32'd0);
    tick();
    checkOutput("bp_drained", {31'b0, dbg_rsp_valid}, 32'd0);

    applyStimulus(1'b1, 3'd3, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 3'd0, 1'b0, 32'h0, 1'b0);
    checkOutput("relock_rsp_data", dbg_rsp_data, KEY3);
    checkOutput("relock_rsp_err", {31'b0, dbg_rsp_err}, 32'd0);
    checkOutput("relock_state", {31'b0, unlocked}, 32'd0);
    readReg(3'd3);
    checkOutput("after_relock_err", {31'b0, dbg_rsp_err}, 32'd1);

    for (int k = 0; k < 3; k++) begin
      unlockAttempt(32'h1111_1111);
      tick();
      checkOutput("fail_locked_out", {31'b0, locked_out}, (k == 2) ? 32'd1 : 32'd0);
      checkOutput("fail_unlock_ready", {31'b0, unlock_ready}, (k == 2) ? 32'd0 : 32'd1);
    end
    unlockAttempt(AUTH);
    tick();
    checkOutput("lockout_ignores_code", {31'b0, unlocked}, 32'd0);
    applyStimulus(1'b0, 3'd0, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 3'd0, 1'b0, 32'h0, 1'b0);
    checkOutput("lockout_ignores_relock", {31'b0, locked_out}, 32'd1);

    dbg_rsp_ready = 1'b0;
    readReg(3'd3);
    checkOutput("lockout_read_err", {31'b0, dbg_rsp_err}, 32'd1);
    checkOutput("pending_valid", {31'b0, dbg_rsp_valid}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_drop", {31'b0, dbg_rsp_valid}, 32'd0);
    tick();
    rst = 1'b0;
    dbg_rsp_ready = 1'b1;
    tick();
    checkOutput("rst2_locked_out", {31'b0, locked_out}, 32'd0);
    checkOutput("rst2_unlock_ready", {31'b0, unlock_ready}, 32'd1);
    unlockAttempt(AUTH);
    tick();
    checkOutput("regs_cleared_no_unlock", {31'b0, unlocked}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
